booth_divider: RTL and testbench

Sequential signed integer divider, the inverse datapath of `booth_multiplier`. It takes a 2N-bit two's-complement dividend and an N-bit two's-complement divisor. It produces an N-bit quotient truncated toward zero and an N-bit remainder with the sign of the dividend. It sits beside the multiplier in the arithmetic unit and runs one restoring-division iteration per clock.

---
 rtl/arith_pkg.sv | 23 ++
 rtl/div_restore_step.sv | 32 +++
 rtl/booth_divider.sv | 179 +++++++++++++++++
 tb/tb_booth_divider.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the sequential arithmetic unit (multiplier/divider).
//   N_DEFAULT   : default operand width N (dividend is 2N wide)
//   state_e     : divider FSM states
//   cnt_width() : width of an iteration counter that can hold 0..2N
// -----------------------------------------------------------------------------
package arith_pkg;

   localparam int N_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic int cnt_width(input int n);
      return $clog2(2 * n + 1);
   endfunction

endpackage

// File: rtl/div_restore_step.sv
// -----------------------------------------------------------------------------
// div_restore_step
// One combinational iteration of unsigned restoring division.
//   rem_i : partial remainder (always < divisor magnitude)
//   bit_i : next dividend bit, shifted into the remainder LSB
//   dsr_i : divisor magnitude (unsigned)
//   rem_o : new partial remainder
//   q_o   : quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_restore_step #(
   parameter int N = 4
) (
   input  logic [N-1:0] rem_i,
   input  logic         bit_i,
   input  logic [N-1:0] dsr_i,
   output logic [N-1:0] rem_o,
   output logic         q_o
);

   logic [N:0]   shifted;
   logic [N-1:0] diff;

   always_comb begin
      shifted = {rem_i, bit_i};
      q_o     = (shifted >= {1'b0, dsr_i});
      // When the trial subtraction succeeds the difference is below the
      // divisor magnitude, so the top bit is always zero and can be dropped.
      diff    = N'(shifted - {1'b0, dsr_i});
      rem_o   = q_o ? diff : shifted[N-1:0];
   end

endmodule

// File: rtl/booth_divider.sv
// -----------------------------------------------------------------------------
// booth_divider
// Sequential signed divider: 2N-bit dividend / N-bit divisor, one restoring
// iteration per clock. Quotient truncates toward zero, remainder takes the
// sign of the dividend.
//   clk         : clock, rising edge
//   reset       : asynchronous active-high reset
//   start       : launch a division (accepted in IDLE or DONE)
//   dividend    : signed 2N-bit dividend, sampled on the start edge
//   divisor     : signed N-bit divisor, sampled on the start edge
//   quotient    : signed N-bit quotient, valid while done
//   remainder   : signed N-bit remainder, valid while done
//   done        : result valid, held until next accepted start or reset
//   div_by_zero : divisor was zero (valid with done)
//   overflow    : quotient does not fit in signed N bits (valid with done)
// -----------------------------------------------------------------------------
module booth_divider
   import arith_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           done,
   output logic           div_by_zero,
   output logic           overflow
);

   localparam int            QW        = 2 * N;
   localparam int            CW        = cnt_width(N);
   localparam logic [CW-1:0] LAST_ITER = CW'(2 * N - 1);
   localparam logic [QW-1:0] QMAX_POS  = QW'((1 << (N - 1)) - 1);
   localparam logic [QW-1:0] QMAX_NEG  = QW'(1 << (N - 1));

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   rem_q, rem_d;
   // Holds |dividend| at start; dividend bits shift out of the top while
   // quotient bits shift in at the bottom, leaving |quotient| after 2N steps.
   logic [QW-1:0]  qd_q, qd_d;
   logic [N-1:0]   dsr_q, dsr_d;
   logic           sdvd_q, sdvd_d;
   logic           sdsr_q, sdsr_d;
   logic [N-1:0]   quo_q, quo_d;
   logic [N-1:0]   rmd_q, rmd_d;
   logic           done_q, done_d;
   logic           dbz_q, dbz_d;
   logic           ovf_q, ovf_d;

   logic [N-1:0]   step_rem;
   logic           step_q;
   logic           neg_quo;

   function automatic logic [QW-1:0] abs_dvd(input logic [QW-1:0] v);
      return v[QW-1] ? QW'(-v) : v;
   endfunction

   function automatic logic [N-1:0] abs_dsr(input logic [N-1:0] v);
      return v[N-1] ? N'(-v) : v;
   endfunction

   // The negative range reaches one further than the positive range.
   function automatic logic quo_overflow(input logic [QW-1:0] mag, input logic neg);
      return neg ? (mag > QMAX_NEG) : (mag > QMAX_POS);
   endfunction

   div_restore_step #(.N(N)) u_step (
      .rem_i (rem_q),
      .bit_i (qd_q[QW-1]),
      .dsr_i (dsr_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   assign neg_quo = sdvd_q ^ sdsr_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      qd_d    = qd_q;
      dsr_d   = dsr_q;
      sdvd_d  = sdvd_q;
      sdsr_d  = sdsr_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      done_d  = done_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               qd_d    = abs_dvd(dividend);
               dsr_d   = abs_dsr(divisor);
               sdvd_d  = dividend[QW-1];
               sdsr_d  = divisor[N-1];
               rem_d   = '0;
               cnt_d   = '0;
               done_d  = 1'b0;
               dbz_d   = 1'b0;
               ovf_d   = 1'b0;
               // A zero divisor skips the iterations; FIX reports it next edge.
               state_d = (divisor == '0) ? ST_FIX : ST_CALC;
            end
         end

         ST_CALC: begin
            rem_d = step_rem;
            qd_d  = {qd_q[QW-2:0], step_q};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d = ST_FIX;
            end
         end

         ST_FIX: begin
            done_d  = 1'b1;
            state_d = ST_DONE;
            if (dsr_q == '0) begin
               dbz_d = 1'b1;
               quo_d = '0;
               rmd_d = '0;
            end else if (quo_overflow(qd_q, neg_quo)) begin
               ovf_d = 1'b1;
               quo_d = '0;
               rmd_d = '0;
            end else begin
               quo_d = neg_quo ? N'(-qd_q) : qd_q[N-1:0];
               rmd_d = sdvd_q ? N'(-rem_q) : rem_q;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         qd_q    <= '0;
         dsr_q   <= '0;
         sdvd_q  <= 1'b0;
         sdsr_q  <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         qd_q    <= qd_d;
         dsr_q   <= dsr_d;
         sdvd_q  <= sdvd_d;
         sdsr_q  <= sdsr_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign quotient    = quo_q;
   assign remainder   = rmd_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_booth_divider.sv
// -----------------------------------------------------------------------------
// tb_booth_divider
// Directed and random checks of booth_divider (N=4) against a plain-integer
// reference model of signed truncating division.
// -----------------------------------------------------------------------------
module tb_booth_divider;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [7:0]   dividend;
   logic [3:0]   divisor;
   logic [3:0]   quotient;
   logic [3:0]   remainder;
   logic         done;
   logic         div_by_zero;
   logic         overflow;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   booth_divider #(.N(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .done        (done),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: integer division truncates toward zero, % follows the dividend.
   task automatic model(input int a, input int b,
                        output logic [3:0] q, output logic [3:0] r,
                        output logic dz, output logic ov, output int lat);
      int qi;
      int ri;
      dz  = 1'b0;
      ov  = 1'b0;
      q   = '0;
      r   = '0;
      lat = 9;
      if (b == 0) begin
         dz  = 1'b1;
         lat = 1;
      end else begin
         qi = a / b;
         ri = a % b;
         if (qi > 7 || qi < -8) begin
            ov = 1'b1;
         end else begin
            q = qi[3:0];
            r = ri[3:0];
         end
      end
   endtask

   task automatic launch(input int a, input int b);
      @(negedge clk);
      dividend = a[7:0];
      divisor  = b[3:0];
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
   endtask

   task automatic wait_done(input int budget, output int lat);
      lat = 0;
      while (!done && lat < budget) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_div(input int a, input int b, input string tag);
      logic [3:0] eq, er;
      logic       edz, eov;
      int         elat, lat;
      model(a, b, eq, er, edz, eov, elat);
      launch(a, b);
      wait_done(20, lat);
      chk({tag, "_lat"}, lat, elat);
      chk({tag, "_done"}, {31'b0, done}, 32'd1);
      chk({tag, "_q"}, {28'b0, quotient}, {28'b0, eq});
      chk({tag, "_r"}, {28'b0, remainder}, {28'b0, er});
      chk({tag, "_dz"}, {31'b0, div_by_zero}, {31'b0, edz});
      chk({tag, "_ov"}, {31'b0, overflow}, {31'b0, eov});
      if (!edz && !eov) begin
         chk({tag, "_inv"}, $signed(quotient) * b + $signed(remainder), a);
      end
   endtask

   initial begin
      logic [3:0] eq, er;
      logic       edz, eov;
      int         elat, lat;
      logic [7:0] ra;
      logic [3:0] rb;

      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_q", {28'b0, quotient}, 32'd0);
      chk("rst_r", {28'b0, remainder}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_dz", {31'b0, div_by_zero}, 32'd0);
      chk("rst_ov", {31'b0, overflow}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_div(35, -5, "d35_m5");
      run_div(-7, 2, "dm7_2");
      run_div(7, -2, "d7_m2");
      run_div(12, 0, "d12_0");
      run_div(64, 1, "d64_1");
      run_div(-128, -8, "dm128_m8");
      run_div(-32, -8, "dm32_m8");

      // start pulsed at E3 must be ignored
      launch(35, -5);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      dividend = 8'd4;
      divisor  = 4'd2;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(20, lat);
      chk("ign_lat", lat + 3, 32'd9);
      chk("ign_q", {28'b0, quotient}, 32'd9);   // -7 as 4-bit pattern 1001
      chk("ign_r", {28'b0, remainder}, 32'd0);

      // start while done: done falls on the same edge
      @(negedge clk);
      dividend = 8'd4;
      divisor  = 4'd2;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("restart_done_low", {31'b0, done}, 32'd0);
      wait_done(20, lat);
      chk("restart_lat", lat, 32'd9);
      chk("restart_q", {28'b0, quotient}, 32'd2);
      chk("restart_r", {28'b0, remainder}, 32'd0);

      // asynchronous reset in the middle of CALC
      launch(35, -5);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_q", {28'b0, quotient}, 32'd0);
      chk("arst_r", {28'b0, remainder}, 32'd0);
      chk("arst_done", {31'b0, done}, 32'd0);
      chk("arst_dz", {31'b0, div_by_zero}, 32'd0);
      chk("arst_ov", {31'b0, overflow}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_div(-12, 3, "dm12_3");

      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom);
         rb = 4'($urandom);
         run_div(int'($signed(ra)), int'($signed(rb)), $sformatf("rnd%0d", i));
      end

      // unused model outputs kept local to avoid stale values
      model(0, 1, eq, er, edz, eov, elat);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
